// File: rtl/demux_vc_pkg.sv
// Shared definitions for the VC demultiplexer: word/count widths, class-bit default
// and the debug FSM state encoding.
package demux_vc_pkg;

    localparam int DATA_W            = 6;
    localparam int COUNT_W           = 5;
    localparam int CLASS_BIT_DEFAULT = 5;

    // Encoding 3 is unused and treated as illegal by the FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSE  = 2'd2
    } state_t;

endpackage

// File: rtl/demux_vc_contador_push.sv
// Free-running push counter for one virtual channel: counts push strobes and
// wraps naturally at 2**COUNT_W.
module contador_push
    import demux_vc_pkg::*;
(
    input  logic               clk,
    input  logic               reset_L,
    input  logic               i_inc,
    output logic [COUNT_W-1:0] o_count
);

    logic [COUNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/demux_vc.sv
// Demultiplexes words from the main FIFO into two virtual-channel FIFOs by one class
// bit, with a one-cycle pop-to-data pipeline and almost-full backpressure.
module demux_vc
    import demux_vc_pkg::*;
#(
    parameter int CLASS_BIT = CLASS_BIT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic [DATA_W-1:0]  main_data,
    input  logic               main_empty,
    input  logic               VC0_almost_full,
    input  logic               VC1_almost_full,
    output logic               main_pop,
    output logic [DATA_W-1:0]  VC0_data,
    output logic [DATA_W-1:0]  VC1_data,
    output logic               VC0_push,
    output logic               VC1_push,
    output logic [COUNT_W-1:0] VC0_count,
    output logic [COUNT_W-1:0] VC1_count,
    output logic [1:0]         state
);

    logic              w_any_full;
    logic              w_class;
    logic              r_pop_delay;
    logic [DATA_W-1:0] r_vc0_data;
    logic [DATA_W-1:0] r_vc1_data;
    logic              r_vc0_push;
    logic              r_vc1_push;
    state_t            r_state;
    state_t            w_state_next;

    // Both flags gate the pop: the destination is unknown until the word returns.
    assign w_any_full = VC0_almost_full | VC1_almost_full;
    assign main_pop   = ~main_empty & ~w_any_full & reset_L;
    assign w_class    = main_data[CLASS_BIT];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_pop_delay <= 1'b0;
            r_vc0_data  <= '0;
            r_vc1_data  <= '0;
            r_vc0_push  <= 1'b0;
            r_vc1_push  <= 1'b0;
        end else begin
            r_pop_delay <= main_pop;
            r_vc0_data  <= '0;
            r_vc1_data  <= '0;
            r_vc0_push  <= 1'b0;
            r_vc1_push  <= 1'b0;
            // An in-flight word is always delivered, regardless of current flags.
            if (r_pop_delay) begin
                if (w_class) begin
                    r_vc1_data <= main_data;
                    r_vc1_push <= 1'b1;
                end else begin
                    r_vc0_data <= main_data;
                    r_vc0_push <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the next-state default is assigned first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = IDLE;
        case (r_state)
            IDLE, ACTIVE, PAUSE: begin
                if (w_any_full) begin
                    w_state_next = PAUSE;
                end else if (!main_empty) begin
                    w_state_next = ACTIVE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    contador_push u_count_vc0 (
        .clk     (clk),
        .reset_L (reset_L),
        .i_inc   (r_vc0_push),
        .o_count (VC0_count)
    );

    contador_push u_count_vc1 (
        .clk     (clk),
        .reset_L (reset_L),
        .i_inc   (r_vc1_push),
        .o_count (VC1_count)
    );

    assign VC0_data = r_vc0_data;
    assign VC1_data = r_vc1_data;
    assign VC0_push = r_vc0_push;
    assign VC1_push = r_vc1_push;
    assign state    = r_state;

endmodule

// File: doc/demux_vc.md
DEMUX_VC -- requirements
Module: demux_vc

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_L, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port main_data, input, 6, head word of the upstream main FIFO, valid the cycle after a pop.
REQ-004 SHALL have port main_empty, input, 1, upstream main FIFO empty flag.
REQ-005 SHALL have ports VC0_almost_full and VC1_almost_full, input, 1 each, almost-full flags of the VC0 and VC1 FIFOs.
REQ-006 SHALL have port main_pop, output, 1, combinational pop request to the main FIFO.
REQ-007 SHALL have ports VC0_data and VC1_data, output, 6 each, registered words to the VC FIFOs.
REQ-008 SHALL have ports VC0_push and VC1_push, output, 1 each, registered push strobes to the VC FIFOs.
REQ-009 SHALL have ports VC0_count and VC1_count, output, 5 each, registered count of words pushed per VC.
REQ-010 SHALL have port state, output, 2, current FSM state for debug.
REQ-011 SHALL define parameter CLASS_BIT, default 5, giving the main_data bit that selects the VC.

Function
REQ-012 SHALL assert main_pop = ~main_empty & ~VC0_almost_full & ~VC1_almost_full & reset_L.
- Both almost-full flags gate the pop: the destination is unknown until the data returns.
REQ-013 SHALL register main_pop into an internal pop_delay flag; main_data is treated as valid only in cycles where pop_delay=1.
REQ-014 SHALL, at the edge ending a pop_delay=1 cycle, route the word by main_data[CLASS_BIT]:
- bit = 0: VC0_data <= main_data, VC0_push <= 1, VC1_data <= 0, VC1_push <= 0.
- bit = 1: the mirror, driving VC1.
REQ-015 SHALL drive both data outputs to 0 and both push outputs to 0 in any cycle following pop_delay=0.
REQ-016 SHALL meet this latency: main_pop in cycle N -> VCx_push high in cycle N+2; back-to-back pops give one push per cycle.
REQ-017 SHALL push an in-flight word (pop_delay=1) even if an almost-full flag rises in the same cycle.
- The VC FIFO almost-full threshold therefore guarantees at least 2 free entries.
REQ-018 SHALL never assert VC0_push and VC1_push in the same cycle.
REQ-019 SHALL increment VCx_count by 1 on each VCx_push, wrapping from 31 to 0.
REQ-020 SHALL implement the FSM with states IDLE=0, ACTIVE=1, PAUSE=2, evaluated each cycle in this order:
- Any almost_full = 1 -> PAUSE.
- Else main_empty = 0 -> ACTIVE.
- Else -> IDLE.
REQ-021 SHALL treat encoding 3 as illegal and recover from it to IDLE on the next edge.
REQ-022 SHALL, with main_empty = 1 and pop_delay = 1 simultaneously, still push the in-flight word.

Reset
REQ-023 SHALL, while reset_L = 0, asynchronously clear all of the following to 0: VC0_data, VC1_data, VC0_push, VC1_push, VC0_count, VC1_count, pop_delay, and state (IDLE).
REQ-024 SHALL force main_pop = 0 while reset_L = 0.
REQ-025 SHALL discard an in-flight word if reset asserts mid-transfer; no push follows reset release until a new pop.

Structure
REQ-026 SHALL take the following from a shared package: FSM state encodings, data width 6, count width 5, and the CLASS_BIT default.
REQ-027 SHALL instantiate a sub-module contador_push (5-bit wrap counter with increment enable and async active-low reset) once per VC.

Verification
REQ-028 SHALL cover single word: main_data=6'h05 (bit5=0), main_empty=0 for 1 cycle -> VC0_push=1 with VC0_data=6'h05 two cycles after main_pop, VC1_push=0, VC0_count=1.
REQ-029 SHALL cover class split: words 6'h21 and 6'h03 back-to-back -> VC1_push with 6'h21 in cycle N+2, VC0_push with 6'h03 in N+3, counts 1/1.
REQ-030 SHALL cover backpressure: VC1_almost_full=1 while main non-empty -> main_pop=0, state=PAUSE; release -> state=ACTIVE, pops resume next cycle.
REQ-031 SHALL cover an in-flight word under almost-full: VC0_almost_full rises in the pop_delay cycle -> that word still pushed, no further pop.
REQ-032 SHALL cover counter wrap: 32 class-0 words -> VC0_count returns to 0, VC1_count stays 0.
REQ-033 SHALL cover reset mid-transfer: reset_L low during the pop_delay cycle -> all outputs 0 immediately, no push after release, state=IDLE.
